// File: rtl/pa_riscv.sv
// Shared encodings for the multi-cycle RV32I core: controller states, opcodes,
// ALU operation codes and datapath mux selects.
package pa_riscv;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BTYPE = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7,
    ALU_SRA = 4'd8
  } alu_op_t;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/alu_op_decoder.sv
// Maps funct3/funct7[5] to an ALU operation for the EXECR/EXECI states.
module alu_op_decoder
  import pa_riscv::*;
(
  input  logic       i_isRtype,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7bit5,
  output logic [3:0] o_aluLogicOperation
);

  alu_op_t op;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    op = ALU_ADD;
    case (i_funct3)
      3'b000:  op = (i_isRtype && i_funct7bit5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b100:  op = ALU_XOR;
      3'b101:  op = i_funct7bit5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD; // 011 (SLTU) is not supported
    endcase
  end

  assign o_aluLogicOperation = op;

endmodule

// File: rtl/multi_cycle_controller.sv
// Main FSM of the multi-cycle RV32I core: sequences the shared ALU and the
// unified memory, producing all datapath enables and mux selects.
module multi_cycle_controller
  import pa_riscv::*;
(
  input  logic       i_clk,
  input  logic       i_srst,
  input  logic [6:0] i_operand,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7bit5,
  input  logic       i_zeroFlag,
  output logic       o_pcWrite,
  output logic       o_irWrite,
  output logic       o_adrSrc,
  output logic       o_memWriteEn,
  output logic       o_regWriteEn,
  output logic [1:0] o_resultSrc,
  output logic [1:0] o_aluSrcA,
  output logic [1:0] o_aluSrcB,
  output logic [3:0] o_aluLogicOperation,
  output logic [3:0] o_state,
  output logic       o_instrDone
);

  state_t     state_q, state_d;
  logic       is_rtype;
  logic [3:0] dec_alu_op;

  assign is_rtype = (state_q == S_EXECR);

  alu_op_decoder u_alu_op_decoder (
    .i_isRtype           (is_rtype),
    .i_funct3            (i_funct3),
    .i_funct7bit5        (i_funct7bit5),
    .o_aluLogicOperation (dec_alu_op)
  );

  always_ff @(posedge i_clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (i_srst) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d             = state_q;
    o_pcWrite           = 1'b0;
    o_irWrite           = 1'b0;
    o_adrSrc            = 1'b0;
    o_memWriteEn        = 1'b0;
    o_regWriteEn        = 1'b0;
    o_resultSrc         = RES_ALUOUT;
    o_aluSrcA           = SRCA_PC;
    o_aluSrcB           = SRCB_RS2;
    o_aluLogicOperation = ALU_ADD;
    o_instrDone         = 1'b0;

    case (state_q)
      S_FETCH: begin
        o_irWrite   = 1'b1;
        o_aluSrcA   = SRCA_PC;
        o_aluSrcB   = SRCB_FOUR;
        o_resultSrc = RES_ALURESULT;
        o_pcWrite   = 1'b1;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        o_aluSrcA = SRCA_OLDPC;
        o_aluSrcB = SRCB_IMM;
        case (i_operand)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECR;
          OP_ITYPE:     state_d = S_EXECI;
          OP_BTYPE:     state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          default: begin
            state_d     = S_FETCH;
            o_instrDone = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        o_aluSrcA = SRCA_RS1;
        o_aluSrcB = SRCB_IMM;
        state_d   = (i_operand == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        o_adrSrc = 1'b1;
        state_d  = S_MEMWB;
      end
      S_MEMWB: begin
        o_resultSrc  = RES_MEMDATA;
        o_regWriteEn = 1'b1;
        o_instrDone  = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        o_adrSrc     = 1'b1;
        o_memWriteEn = 1'b1;
        o_instrDone  = 1'b1;
        state_d      = S_FETCH;
      end
      S_EXECR: begin
        o_aluSrcA           = SRCA_RS1;
        o_aluSrcB           = SRCB_RS2;
        o_aluLogicOperation = dec_alu_op;
        state_d             = S_ALUWB;
      end
      S_EXECI: begin
        o_aluSrcA           = SRCA_RS1;
        o_aluSrcB           = SRCB_IMM;
        o_aluLogicOperation = dec_alu_op;
        state_d             = S_ALUWB;
      end
      S_ALUWB: begin
        o_resultSrc  = RES_ALUOUT;
        o_regWriteEn = 1'b1;
        o_instrDone  = 1'b1;
        state_d      = S_FETCH;
      end
      S_JAL: begin
        // PC loads the target held in ALUOut while the ALU forms the link address.
        o_aluSrcA   = SRCA_OLDPC;
        o_aluSrcB   = SRCB_FOUR;
        o_resultSrc = RES_ALUOUT;
        o_pcWrite   = 1'b1;
        state_d     = S_ALUWB;
      end
      S_BRANCH: begin
        o_aluSrcA           = SRCA_RS1;
        o_aluSrcB           = SRCB_RS2;
        o_aluLogicOperation = ALU_SUB;
        o_resultSrc         = RES_ALUOUT;
        o_instrDone         = 1'b1;
        case (i_funct3)
          3'b000:  o_pcWrite = i_zeroFlag;
          3'b001:  o_pcWrite = ~i_zeroFlag;
          default: o_pcWrite = 1'b0;
        endcase
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset silences the datapath in the very cycle it is asserted.
    if (i_srst) begin
      o_pcWrite           = 1'b0;
      o_irWrite           = 1'b0;
      o_adrSrc            = 1'b0;
      o_memWriteEn        = 1'b0;
      o_regWriteEn        = 1'b0;
      o_resultSrc         = 2'b00;
      o_aluSrcA           = 2'b00;
      o_aluSrcB           = 2'b00;
      o_aluLogicOperation = ALU_ADD;
      o_instrDone         = 1'b0;
    end
  end

  assign o_state = i_srst ? 4'd0 : state_q;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Randomized bench for multi_cycle_controller, checked every cycle against an
// instruction-level model (state path per opcode plus per-state datapath controls).
module tb_multi_cycle_controller;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       adr_src;
    logic       mem_we;
    logic       reg_we;
    logic [1:0] result_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [3:0] alu_op;
    logic [3:0] state;
    logic       done;
  } outs_t;

  logic       clk = 1'b0;
  logic       srst = 1'b1;
  logic [6:0] operand = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7bit5 = 1'b0;
  logic       zero_flag = 1'b0;

  logic       pc_write, ir_write, adr_src, mem_we, reg_we, instr_done;
  logic [1:0] result_src, src_a, src_b;
  logic [3:0] alu_op, state;

  multi_cycle_controller dut (
    .i_clk               (clk),
    .i_srst              (srst),
    .i_operand           (operand),
    .i_funct3            (funct3),
    .i_funct7bit5        (funct7bit5),
    .i_zeroFlag          (zero_flag),
    .o_pcWrite           (pc_write),
    .o_irWrite           (ir_write),
    .o_adrSrc            (adr_src),
    .o_memWriteEn        (mem_we),
    .o_regWriteEn        (reg_we),
    .o_resultSrc         (result_src),
    .o_aluSrcA           (src_a),
    .o_aluSrcB           (src_b),
    .o_aluLogicOperation (alu_op),
    .o_state             (state),
    .o_instrDone         (instr_done)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  outs_t      exp_o = '0;
  bit         exp_valid = 1'b0;
  int         path[$];
  int         obs[$];
  int         done_seen;
  int         done_state;
  int         wr_seen;
  logic [3:0] last_exec_alu = 4'd0;
  logic       last_branch_pc = 1'b0;
  int         force_zero = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // ALU operation implied by funct fields for an ALU-type instruction.
  function automatic logic [3:0] alu_code(input bit is_r, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0:    return (is_r && f7) ? 4'd1 : 4'd0;
      3'd1:    return 4'd6;
      3'd2:    return 4'd5;
      3'd4:    return 4'd4;
      3'd5:    return f7 ? 4'd8 : 4'd7;
      3'd6:    return 4'd3;
      3'd7:    return 4'd2;
      default: return 4'd0;
    endcase
  endfunction

  // Sequence of states an instruction walks through, starting at FETCH.
  function automatic void build_path(input logic [6:0] op);
    path.delete();
    path.push_back(0);
    path.push_back(1);
    case (op)
      7'b0000011: begin path.push_back(2); path.push_back(3); path.push_back(4); end
      7'b0100011: begin path.push_back(2); path.push_back(5); end
      7'b0110011: begin path.push_back(6); path.push_back(8); end
      7'b0010011: begin path.push_back(7); path.push_back(8); end
      7'b1100011: path.push_back(10);
      7'b1101111: begin path.push_back(9); path.push_back(8); end
      default: ;
    endcase
  endfunction

  function automatic outs_t model_outs(input int st, input logic [2:0] f3, input logic f7,
                                       input logic z, input bit last);
    outs_t o = '0;
    o.state = st[3:0];
    o.done  = last;
    case (st)
      0:  begin o.ir_write = 1; o.pc_write = 1; o.result_src = 2; o.src_a = 0; o.src_b = 2; end
      1:  begin o.src_a = 1; o.src_b = 1; end
      2:  begin o.src_a = 2; o.src_b = 1; end
      3:  o.adr_src = 1;
      4:  begin o.result_src = 1; o.reg_we = 1; end
      5:  begin o.adr_src = 1; o.mem_we = 1; end
      6:  begin o.src_a = 2; o.src_b = 0; o.alu_op = alu_code(1, f3, f7); end
      7:  begin o.src_a = 2; o.src_b = 1; o.alu_op = alu_code(0, f3, f7); end
      8:  begin o.result_src = 0; o.reg_we = 1; end
      9:  begin o.src_a = 1; o.src_b = 2; o.result_src = 0; o.pc_write = 1; end
      10: begin
        o.src_a = 2; o.src_b = 0; o.alu_op = 4'd1; o.result_src = 0;
        o.pc_write = (f3 == 3'd0) ? z : (f3 == 3'd1) ? ~z : 1'b0;
      end
      default: ;
    endcase
    return o;
  endfunction

  always @(negedge clk) begin
    if (exp_valid) begin
      check("pcWrite",     64'(pc_write),   64'(exp_o.pc_write));
      check("irWrite",     64'(ir_write),   64'(exp_o.ir_write));
      check("adrSrc",      64'(adr_src),    64'(exp_o.adr_src));
      check("memWriteEn",  64'(mem_we),     64'(exp_o.mem_we));
      check("regWriteEn",  64'(reg_we),     64'(exp_o.reg_we));
      check("resultSrc",   64'(result_src), 64'(exp_o.result_src));
      check("aluSrcA",     64'(src_a),      64'(exp_o.src_a));
      check("aluSrcB",     64'(src_b),      64'(exp_o.src_b));
      check("aluOp",       64'(alu_op),     64'(exp_o.alu_op));
      check("state",       64'(state),      64'(exp_o.state));
      check("instrDone",   64'(instr_done), 64'(exp_o.done));
      if (state != 4'd0)
        check("single_enable", 64'((int'(pc_write) + int'(mem_we) + int'(reg_we)) <= 1), 64'd1);
      obs.push_back(int'(state));
      if (instr_done) begin done_seen++; done_state = int'(state); end
      if (mem_we || reg_we) wr_seen++;
      if (state == 4'd6 || state == 4'd7) last_exec_alu = alu_op;
      if (state == 4'd10) last_branch_pc = pc_write;
    end
  end

  function automatic logic [63:0] pack_obs();
    logic [63:0] v = '0;
    foreach (obs[i]) v = (v << 4) | 64'(obs[i] & 15);
    return v;
  endfunction

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input int abort_step);
    build_path(op);
    operand    = op;
    funct3     = f3;
    funct7bit5 = f7;
    for (int k = 0; k < path.size(); k++) begin
      if (k == abort_step) begin
        srst      = 1'b1;
        exp_o     = '0;
        exp_valid = 1'b1;
        @(posedge clk); #1;
        srst = 1'b0;
        break;
      end
      zero_flag = (force_zero < 0) ? 1'($urandom_range(0, 1)) : 1'(force_zero);
      exp_o     = model_outs(path[k], f3, f7, zero_flag, k == path.size() - 1);
      exp_valid = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic directed(input string name, input logic [6:0] op, input logic [2:0] f3,
                          input logic f7, input int abort_step, input logic [63:0] seq);
    obs.delete();
    done_seen  = 0;
    done_state = -1;
    wr_seen    = 0;
    run_instr(op, f3, f7, abort_step);
    check(name, pack_obs(), seq);
  endtask

  initial begin
    srst      = 1'b1;
    exp_o     = '0;
    exp_valid = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    srst = 1'b0;

    directed("lw_seq", 7'b0000011, 3'd2, 1'b0, -1, 64'h01234);
    check("lw_done_count", 64'(done_seen), 64'd1);
    check("lw_done_state", 64'(done_state), 64'd4);
    directed("sw_seq", 7'b0100011, 3'd2, 1'b0, -1, 64'h0125);
    check("sw_done_state", 64'(done_state), 64'd5);

    directed("rsub_seq", 7'b0110011, 3'd0, 1'b1, -1, 64'h0168);
    check("rsub_alu", 64'(last_exec_alu), 64'd1);
    directed("iadd_seq", 7'b0010011, 3'd0, 1'b1, -1, 64'h0178);
    check("iadd_alu", 64'(last_exec_alu), 64'd0);
    directed("rsra_seq", 7'b0110011, 3'd5, 1'b1, -1, 64'h0168);
    check("rsra_alu", 64'(last_exec_alu), 64'd8);

    force_zero = 1;
    directed("beq_z1_seq", 7'b1100011, 3'd0, 1'b0, -1, 64'h01a);
    check("beq_z1_pc", 64'(last_branch_pc), 64'd1);
    force_zero = 0;
    directed("beq_z0_seq", 7'b1100011, 3'd0, 1'b0, -1, 64'h01a);
    check("beq_z0_pc", 64'(last_branch_pc), 64'd0);
    force_zero = 1;
    directed("bne_z1_seq", 7'b1100011, 3'd1, 1'b0, -1, 64'h01a);
    check("bne_z1_pc", 64'(last_branch_pc), 64'd0);
    force_zero = 0;
    directed("bne_z0_seq", 7'b1100011, 3'd1, 1'b0, -1, 64'h01a);
    check("bne_z0_pc", 64'(last_branch_pc), 64'd1);
    force_zero = -1;

    directed("jal_seq", 7'b1101111, 3'd0, 1'b0, -1, 64'h0198);
    check("jal_wr_count", 64'(wr_seen), 64'd1);

    directed("lw_abort_seq", 7'b0000011, 3'd2, 1'b0, 3, 64'h0120);
    check("lw_abort_writes", 64'(wr_seen), 64'd0);
    directed("sw_after_reset", 7'b0100011, 3'd2, 1'b0, -1, 64'h0125);

    directed("illegal_seq", 7'b1111111, 3'd0, 1'b0, -1, 64'h01);
    check("illegal_writes", 64'(wr_seen), 64'd0);
    check("illegal_done_state", 64'(done_state), 64'd1);

    for (int n = 0; n < 120; n++) begin
      logic [6:0] op;
      int         abort_step;
      case ($urandom_range(0, 6))
        0: op = 7'b0000011;
        1: op = 7'b0100011;
        2: op = 7'b0110011;
        3: op = 7'b0010011;
        4: op = 7'b1100011;
        5: op = 7'b1101111;
        default: op = ($urandom_range(0, 1) == 0) ? 7'b1111111 : 7'b0000000;
      endcase
      abort_step = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), abort_step);
    end

    exp_valid = 1'b0;
    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_cycle_controller.md
# multi_cycle_controller

Main controller FSM for the multi-cycle RV32I core, the successor to the single-cycle datapath. It sequences a shared ALU and a single unified instruction/data memory over several cycles per instruction. From the opcode, funct fields and the ALU zero flag, it produces every register enable, mux select and ALU operation for the datapath. Supported instructions: LW, SW, R-type ALU, I-type ALU, BEQ/BNE and JAL.

## Interface
- No parameters. State, opcode and ALU-operation encodings come from `pa_riscv`.
- `i_clk` in 1: the single clock.
- `i_srst` in 1: reset, synchronous and active-high.
- `i_operand` in 7: `instruction[6:0]`, taken from the instruction register.
- `i_funct3` in 3: `instruction[14:12]`.
- `i_funct7bit5` in 1: `instruction[30]`.
- `i_zeroFlag` in 1: ALU result equals 0.
- `o_pcWrite` out 1: load PC from result bus.
- `o_irWrite` out 1: load instruction register and oldPc.
- `o_adrSrc` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `o_memWriteEn` out 1: memory write enable.
- `o_regWriteEn` out 1: register-file write enable.
- `o_resultSrc` out 2: result bus select. 00 = ALUOut, 01 = memData, 10 = ALU result.
- `o_aluSrcA` out 2: ALU A select. 00 = PC, 01 = oldPc, 10 = rs1.
- `o_aluSrcB` out 2: ALU B select. 00 = rs2, 01 = immediate, 10 = constant 4.
- `o_aluLogicOperation` out 4: ALU operation code.
- `o_state` out 4: current state, for debug and verification.
- `o_instrDone` out 1: one-cycle pulse on the last cycle of each instruction.

## Operation
States and encodings: FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5, EXECR = 6, EXECI = 7, ALUWB = 8, JAL = 9, BRANCH = 10.

State actions (any output not listed is 0; ALU operation is ADD unless stated):
- FETCH: adrSrc = 0, irWrite = 1, aluSrcA = PC, aluSrcB = 4, resultSrc = ALU result, pcWrite = 1. Next state is DECODE.
- DECODE: aluSrcA = oldPc, aluSrcB = immediate. ALUOut receives the branch/jump target. Next state by opcode:
  - 0000011 → MEMADR
  - 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - any other opcode → FETCH, with `o_instrDone` = 1. The illegal instruction is skipped.
- MEMADR: aluSrcA = rs1, aluSrcB = immediate. Next state is MEMREAD if the opcode is LW, else MEMWRITE.
- MEMREAD: adrSrc = 1. Next state is MEMWB.
- MEMWB: resultSrc = memData, regWriteEn = 1, instrDone = 1. Next state is FETCH.
- MEMWRITE: adrSrc = 1, memWriteEn = 1, instrDone = 1. Next state is FETCH.
- EXECR: aluSrcA = rs1, aluSrcB = rs2, ALU operation from `alu_op_decoder`. Next state is ALUWB.
- EXECI: aluSrcA = rs1, aluSrcB = immediate, ALU operation from `alu_op_decoder`. Next state is ALUWB.
- ALUWB: resultSrc = ALUOut, regWriteEn = 1, instrDone = 1. Next state is FETCH.
- JAL: aluSrcA = oldPc, aluSrcB = 4, resultSrc = ALUOut, pcWrite = 1. The PC takes the target; ALUOut takes the link address. Next state is ALUWB.
- BRANCH: aluSrcA = rs1, aluSrcB = rs2, operation SUB, resultSrc = ALUOut, instrDone = 1. pcWrite = i_zeroFlag when funct3 = 000 (BEQ), ~i_zeroFlag when funct3 = 001 (BNE), 0 for any other funct3. Next state is FETCH.

ALU operation decode, keyed on funct3:
- 000: SUB for R-type with funct7bit5 = 1; ADD otherwise (I-type always ADD).
- 001: SLL. 010: SLT. 100: XOR. 110: OR. 111: AND.
- 101: SRA if funct7bit5 = 1, else SRL.
- 011: ADD (SLTU is unsupported).

## Timing
- Moore-style outputs, decoded combinationally from the state register.
  - Exception: BRANCH `o_pcWrite` follows `i_zeroFlag` in the same cycle.
  - Exception: EXECR/EXECI ALU operation follows the funct inputs in the same cycle.
- The state register updates on the rising edge of `i_clk`.
- Cycles per instruction: LW 5, SW 4, R-type 4, I-type 4, JAL 4, BEQ/BNE 3, illegal 2.
- Reset: while `i_srst` = 1, all outputs are forced to 0, which includes ALU operation ADD and `o_state` 0. The next state is FETCH. The first FETCH outputs appear in the cycle after `i_srst` falls.
- Reset mid-instruction: the instruction is abandoned and no enable is asserted in the reset cycle. Memory and registers keep whatever was committed before reset.
- At most one of pcWrite, memWriteEn and regWriteEn is asserted in any cycle, except FETCH, which asserts irWrite and pcWrite together.
- `o_instrDone` coincides exactly with the last state of each instruction path.

## Structure
- `pa_riscv` gains these typedefs and constants:
  - `state_t` enum
  - opcode constants (LW, SW, RTYPE, ITYPE, BTYPE, JAL)
  - ALU codes: ADD = 0, SUB = 1, AND = 2, OR = 3, XOR = 4, SLT = 5, SLL = 6, SRL = 7, SRA = 8
  - mux-select constants for A, B and result
- One sub-module: `alu_op_decoder`, purely combinational. Inputs: an isRtype flag, funct3 and funct7bit5. Output: `aluLogicOperation`.

## Test plan
- Release reset, then feed LW (0000011) → `o_state` sequence 0,1,2,3,4,0. MEMWB has regWriteEn = 1 and resultSrc = 01. `o_instrDone` pulses only in MEMWB.
- SW (0100011) → sequence 0,1,2,5,0. memWriteEn = 1 only in state 5, with adrSrc = 1.
- R-type funct3 = 000, funct7bit5 = 1 → EXECR ALU operation = 1 (SUB). Same inputs on an I-type opcode → operation 0. funct3 = 101, funct7bit5 = 1 → 8 (SRA).
- BEQ with zeroFlag = 1 → pcWrite = 1 in BRANCH. With zeroFlag = 0 → pcWrite = 0. BNE inverts both cases. Each takes 3 cycles.
- JAL → sequence 0,1,9,8,0. pcWrite = 1 in JAL; regWriteEn = 1 in ALUWB.
- Assert `i_srst` in MEMREAD → all outputs 0 in that cycle, then FETCH. Opcode 1111111 → 0,1,0 with no write enables asserted.
